mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the instruction-fetch stage and the data
//  memory stage. Each requester sends a one-cycle mask pulse, the same way the
//  data-memory stage drives dmem_rmask/dmem_wmask.
//  The block buffers one request per requester, issues it on the shared port and
//  waits for mem_resp. It then routes read data and the response back to the owner.
//  Placed between the pipeline (fetch and memory stages) and the memory model / cache.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; mask width is DATA_W/8
// PORTS
//  clk          in   1         clock, all state updates on posedge
//  rst          in   1         asynchronous, active-low reset
//  imem_addr    in   ADDR_W    fetch address, valid when imem_rmask!=0
//  imem_rmask   in   DATA_W/8  fetch request pulse (nonzero = request)
//  imem_rdata   out  DATA_W    fetch read data, valid when imem_resp=1
//  imem_resp    out  1         fetch response, one-cycle pulse
//  dmem_addr    in   ADDR_W    data address
//  dmem_rmask   in   DATA_W/8  load request pulse
//  dmem_wmask   in   DATA_W/8  store request pulse
//  dmem_wdata   in   DATA_W    store data, valid with dmem_wmask
//  dmem_rdata   out  DATA_W    load data, valid when dmem_resp=1
//  dmem_resp    out  1         data response, one-cycle pulse
//  mem_addr     out  ADDR_W    shared-port address
//  mem_rmask    out  DATA_W/8  shared-port read mask, one-cycle pulse
//  mem_wmask    out  DATA_W/8  shared-port write mask, one-cycle pulse
//  mem_wdata    out  DATA_W    shared-port write data
//  mem_rdata    in   DATA_W    shared-port read data
//  mem_resp     in   1         shared-port response; never in the same cycle as issue
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, pend_i=pend_d=0, state IDLE, rr_last=I.
//  - Capture: a nonzero mask on a port with an empty buffer sets pend_x and latches
//    addr/masks/wdata at the posedge.
//    A new pulse while pend_x=1 or while port x is in service is a protocol error:
//    it is dropped and flagged by an assertion (simulation only).
//  - A dmem pulse with both rmask and wmask nonzero is also an assertion error.
//    If it occurs, the write mask is issued and the read mask is dropped.
//  - FSM states IDLE, BUSY_I, BUSY_D.
//     IDLE: if pend_d | pend_i, grant the winner. In the same cycle drive mem_*
//       from the winner's buffer for exactly one cycle, clear that pend bit and go
//       to BUSY_x. Otherwise all mem_* are 0.
//       Capture-to-issue latency is 1 cycle minimum.
//     BUSY_x: mem_* masks are 0 and mem_addr/mem_wdata are held.
//       On mem_resp=1, pulse x_resp=1 for that cycle with x_rdata=mem_rdata
//       (combinational pass-through). Return to IDLE and record rr_last=x.
//       Back-to-back: the next issue is no earlier than the cycle after mem_resp.
//  - mem_resp in IDLE is ignored: no resp pulse is generated.
//  - The non-owner's resp is always 0 and its rdata is always 0.
//  - Simultaneous events: a capture on port y during BUSY_x is buffered normally.
//    A response and a fresh capture on the same port in the same cycle are legal;
//    the new request is buffered.
//  - Reset mid-transaction: the outstanding request is abandoned. A later mem_resp
//    arrives in IDLE and is ignored.
//  - Default priority (fixed): data over fetch when both are pending in IDLE.
//    This prevents pipeline deadlock, because the memory stage blocks fetch.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    In IDLE, if both are pending, the port not equal to rr_last is granted;
//    otherwise the single pending port is granted. No port waits more than one grant.
//  ARB_ROUND_ROBIN_EN undefined:
//    Fixed data-over-fetch priority. The rr_last register is still kept but is not
//    used for grant decisions.
// TESTING
//  1 Reset: hold rst=0 with random inputs -> all outputs 0.
//    Release, no requests -> mem_rmask=mem_wmask=0 forever.
//  2 Single fetch: imem_rmask=F at addr 0x1000.
//    -> next cycle mem_rmask=F, mem_addr=0x1000.
//    mem_resp 3 cycles later with 0xDEAD_BEEF -> imem_resp=1 with that data;
//    dmem_resp stays 0.
//  3 Store: dmem_wmask=0x3, addr 0x2002, wdata 0x0000_1234
//    -> mem_wmask=0x3, mem_wdata=0x0000_1234, mem_rmask=0.
//    On mem_resp -> dmem_resp pulse.
//  4 Collision: imem and dmem pulse in the same cycle -> data issued first, then
//    fetch the cycle after the first mem_resp.
//    With ARB_ROUND_ROBIN_EN and rr_last=D -> fetch issued first.
//  5 Busy capture: fetch in service, dmem_rmask pulse arrives -> buffered; issued
//    the cycle after the fetch resp. Each resp pulse goes only to its owner.
//  6 Reset mid-op: rst=0 during BUSY_D, then stray mem_resp after release
//    -> no dmem_resp/imem_resp pulse, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, data port and the shared memory port.
// slave is the arbiter's view; master is the pipeline/memory side driving requests and responses.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic [ADDR_W-1:0] imem_addr;
    logic [MASK_W-1:0] imem_rmask;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_resp;

    logic [ADDR_W-1:0] dmem_addr;
    logic [MASK_W-1:0] dmem_rmask;
    logic [MASK_W-1:0] dmem_wmask;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    logic [ADDR_W-1:0] mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages with a one-deep buffer per requester.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on collision; default is data-over-fetch.
//
// state  | meaning
// IDLE   | shared port free; issues the winning buffered request for one cycle
// BUSY_I | fetch request outstanding, waiting for mem_resp
// BUSY_D | data request outstanding, waiting for mem_resp
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic RR_I = 1'b0;
    localparam logic RR_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pend_i_q, pend_i_d;
    logic              pend_d_q, pend_d_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic [MASK_W-1:0] i_rmask_q, i_rmask_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [MASK_W-1:0] d_rmask_q, d_rmask_d;
    logic [MASK_W-1:0] d_wmask_q, d_wmask_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

    logic              issue;
    logic              grant_d;
    logic [ADDR_W-1:0] iss_addr;
    logic [MASK_W-1:0] iss_rmask;
    logic [MASK_W-1:0] iss_wmask;
    logic [DATA_W-1:0] iss_wdata;
    logic              resp_i;
    logic              resp_d;
    logic              req_i;
    logic              req_d;
    logic              cap_i;
    logic              cap_d;
    logic              in_svc_i;
    logic              in_svc_d;

    always_comb begin
        issue = (state_q == IDLE) && (pend_i_q || pend_d_q);
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = pend_d_q && (!pend_i_q || (rr_last_q == RR_I));
`else
        grant_d = pend_d_q;
`endif
        iss_addr  = grant_d ? d_addr_q  : i_addr_q;
        iss_rmask = grant_d ? d_rmask_q : i_rmask_q;
        iss_wmask = grant_d ? d_wmask_q : '0;
        iss_wdata = grant_d ? d_wdata_q : '0;
        resp_i    = (state_q == BUSY_I) && bus.mem_resp;
        resp_d    = (state_q == BUSY_D) && bus.mem_resp;
    end

    // Issue is combinational from the buffers so a capture reaches the port one cycle later.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_rmask = '0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;
        if (issue) begin
            bus.mem_addr  = iss_addr;
            bus.mem_rmask = iss_rmask;
            bus.mem_wmask = iss_wmask;
            bus.mem_wdata = iss_wdata;
        end else if (state_q != IDLE) begin
            bus.mem_addr  = hold_addr_q;
            bus.mem_wdata = hold_wdata_q;
        end
        bus.imem_resp  = resp_i;
        bus.dmem_resp  = resp_d;
        bus.imem_rdata = resp_i ? bus.mem_rdata : '0;
        bus.dmem_rdata = resp_d ? bus.mem_rdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        pend_i_d     = pend_i_q;
        pend_d_d     = pend_d_q;
        rr_last_d    = rr_last_q;
        i_addr_d     = i_addr_q;
        i_rmask_d    = i_rmask_q;
        d_addr_d     = d_addr_q;
        d_rmask_d    = d_rmask_q;
        d_wmask_d    = d_wmask_q;
        d_wdata_d    = d_wdata_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;

        // A port finishing service this cycle may accept its next request.
        in_svc_i = (state_q == BUSY_I) && !bus.mem_resp;
        in_svc_d = (state_q == BUSY_D) && !bus.mem_resp;
        req_i    = |bus.imem_rmask;
        req_d    = (|bus.dmem_rmask) || (|bus.dmem_wmask);
        cap_i    = req_i && !pend_i_q && !in_svc_i;
        cap_d    = req_d && !pend_d_q && !in_svc_d;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    hold_addr_d  = iss_addr;
                    hold_wdata_d = iss_wdata;
                    if (grant_d) begin
                        pend_d_d = 1'b0;
                        state_d  = BUSY_D;
                    end else begin
                        pend_i_d = 1'b0;
                        state_d  = BUSY_I;
                    end
                end
            end
            BUSY_I: begin
                if (bus.mem_resp) begin
                    state_d   = IDLE;
                    rr_last_d = RR_I;
                end
            end
            BUSY_D: begin
                if (bus.mem_resp) begin
                    state_d   = IDLE;
                    rr_last_d = RR_D;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_i) begin
            pend_i_d  = 1'b1;
            i_addr_d  = bus.imem_addr;
            i_rmask_d = bus.imem_rmask;
        end
        // A store wins over a simultaneous load mask on the data port.
        if (cap_d) begin
            pend_d_d  = 1'b1;
            d_addr_d  = bus.dmem_addr;
            d_wmask_d = bus.dmem_wmask;
            d_rmask_d = (|bus.dmem_wmask) ? '0 : bus.dmem_rmask;
            d_wdata_d = bus.dmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            rr_last_q    <= RR_I;
            i_addr_q     <= '0;
            i_rmask_q    <= '0;
            d_addr_q     <= '0;
            d_rmask_q    <= '0;
            d_wmask_q    <= '0;
            d_wdata_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            rr_last_q    <= rr_last_d;
            i_addr_q     <= i_addr_d;
            i_rmask_q    <= i_rmask_d;
            d_addr_q     <= d_addr_d;
            d_rmask_q    <= d_rmask_d;
            d_wmask_q    <= d_wmask_d;
            d_wdata_q    <= d_wdata_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    // Protocol checks on the requesters; ignored by synthesis.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(req_i && !cap_i))
                else $error("imem request dropped: buffer full or port in service");
            assert (!(req_d && !cap_d))
                else $error("dmem request dropped: buffer full or port in service");
            assert (!((|bus.dmem_rmask) && (|bus.dmem_wmask)))
                else $error("dmem read and write masks in the same pulse; read dropped");
        end
    end
endmodule
